wb_port_arbiter: RTL
====================

Name: wb_port_arbiter

Overview:
- Sits between the two MEM/WB pipeline lanes and the register file in the two-issue core.
- Merges three write sources onto the two register-file write ports: lane 0 (older), lane 1 (younger), and the long-latency unit (mul/div).
- Long-latency results are buffered in a small FIFO and drained only into write-port slots the lanes leave idle.
- Resolves same-cycle intra-bundle WAW conflicts; all write-port outputs are registered.

Parameters:
- DEPTH, 2, long-latency result FIFO entries (power of two, ≥2)
- PTR_W, 1, FIFO pointer width (log2 DEPTH)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- reg_write0  in  1  lane 0 (older) write request
- rd0  in  5  lane 0 destination
- data0  in  32  lane 0 write data (already muxed ALU/mem)
- reg_write1  in  1  lane 1 (younger) write request
- rd1  in  5  lane 1 destination
- data1  in  32  lane 1 write data
- lu_valid  in  1  long-latency result valid
- lu_rd  in  5  long-latency destination
- lu_data  in  32  long-latency result
- lu_ready  out  1  FIFO can accept (valid/ready handshake)
- wp0_en  out  1  write port 0 enable
- wp0_addr  out  5  write port 0 address
- wp0_data  out  32  write port 0 data
- wp1_en  out  1  write port 1 enable
- wp1_addr  out  5  write port 1 address
- wp1_data  out  32  write port 1 data
- lu_pending  out  PTR_W+1  FIFO occupancy

Behaviour:
- Reset (rst=0, async): all wp* outputs 0, FIFO emptied, pointers 0, lu_pending=0, lu_ready=0 while rst is low.
- lu_ready = rst && (count != DEPTH), taken from the registered count. There is no pass-through when full, even if the FIFO pops in the same cycle.
- Push: lu_valid && lu_ready at the clock edge writes {lu_rd, lu_data} at wptr. wptr wraps modulo DEPTH. A result with lu_rd=0 is accepted and then discarded (not pushed).
- Effective lane writes:
  - e0 = reg_write0 && rd0!=0
  - e1 = reg_write1 && rd1!=0
  - If e0 && e1 && rd0==rd1, e0 is cleared (younger lane 1 wins).
- Lane writes are never stalled; lanes have absolute priority.
- Free slots: free = 2 - (e0 + e1).
- Drain: n = min(free, count) entries are popped from rptr in FIFO order. rptr wraps modulo DEPTH.
- Slot assignment: the ordered writer list is (lane0 if e0, lane1 if e1, FIFO head, FIFO head+1).
  - The first valid writer goes to wp0 and the second to wp1.
  - Unused ports have en=0, addr=0, data=0.
- Latency: wp* outputs register the assignment one cycle after the inputs are sampled. A FIFO entry reaches a port no earlier than 2 cycles after acceptance.
- Simultaneous push and pop: count_next = count + push - n. Occupancy never exceeds DEPTH.
- Two FIFO entries with the same rd drained in one cycle: the older goes to wp0 and the younger to wp1. The register file gives wp1 precedence on equal addresses, so the younger value wins.
- Ordering between the long-latency unit and the lanes is guaranteed by the upstream scoreboard; this block performs no rd check between them.
- lu_pending = count, registered.

Test Plan:
- Reset mid-operation: FIFO holds 2 entries, pull rst low asynchronously -> wp*_en=0, lu_pending=0, lu_ready=0 immediately; after release, lu_ready=1 and the stale entries are never written.
- Both lanes write, rd0=3/0xAAAA, rd1=5/0xBBBB -> next cycle wp0=(1,3,0xAAAA), wp1=(1,5,0xBBBB); a FIFO entry is held and lu_pending is unchanged.
- WAW in bundle, rd0=rd1=7, data0=0x1, data1=0x2, FIFO holds rd=9/0x99 -> wp0=(1,7,0x2), wp1=(1,9,0x99); lu_pending decrements by 1.
- rd0=0 with reg_write0=1, lane1 idle, FIFO holds rd=4/0x44 and rd=6/0x66 -> wp0=(1,4,0x44), wp1=(1,6,0x66); lu_pending goes from 2 to 0.
- Push 2 results while both lanes write every cycle -> lu_ready=0 after the 2nd accept and a 3rd lu_valid is held off; drop the lanes for 1 cycle -> both entries drain and lu_ready=1 on the next cycle.
- Push 5 results in sequence with alternating lane traffic to force pointer wrap -> all 5 appear on the ports in push order with correct rd/data and none are lost or duplicated.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: merges two pipeline lanes and a buffered long-latency
// result stream onto the two register-file write ports, lanes always first.
module wb_port_arbiter #(
    parameter int DEPTH = 2,
    parameter int PTR_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             reg_write0,
    input  logic [4:0]       rd0,
    input  logic [31:0]      data0,
    input  logic             reg_write1,
    input  logic [4:0]       rd1,
    input  logic [31:0]      data1,
    input  logic             lu_valid,
    input  logic [4:0]       lu_rd,
    input  logic [31:0]      lu_data,
    output logic             lu_ready,
    output logic             wp0_en,
    output logic [4:0]       wp0_addr,
    output logic [31:0]      wp0_data,
    output logic             wp1_en,
    output logic [4:0]       wp1_addr,
    output logic [31:0]      wp1_data,
    output logic [PTR_W:0]   lu_pending
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [4:0]       rd_mem   [DEPTH];
    logic [31:0]      data_mem [DEPTH];

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W-1:0] rptr_nx;
    logic [PTR_W:0]   count_q, count_d;

    logic             push;
    logic             e0, e1;
    logic [1:0]       free_slots;
    logic [1:0]       n_pop;

    logic             s0_en_d, s1_en_d;
    logic [4:0]       s0_addr_d, s1_addr_d;
    logic [31:0]      s0_data_d, s1_data_d;

    logic             wp0_en_q, wp1_en_q;
    logic [4:0]       wp0_addr_q, wp1_addr_q;
    logic [31:0]      wp0_data_q, wp1_data_q;

    // Ready comes from the registered count only, so a full FIFO never takes a
    // new result even in a cycle where it also drains.
    assign lu_ready = rst && (count_q != FULL_CNT);
    assign push     = lu_valid && lu_ready && (lu_rd != 5'd0);

    // The younger lane wins a same-destination conflict inside the bundle.
    assign e1 = reg_write1 && (rd1 != 5'd0);
    assign e0 = reg_write0 && (rd0 != 5'd0) && !(e1 && (rd0 == rd1));

    assign free_slots = 2'd2 - {1'b0, e0} - {1'b0, e1};
    assign n_pop      = (count_q < (PTR_W + 1)'(free_slots)) ? count_q[1:0] : free_slots;
    assign rptr_nx    = rptr_q + PTR_W'(1);

    assign count_d = count_q + (PTR_W + 1)'(push) - (PTR_W + 1)'(n_pop);
    assign wptr_d  = push ? wptr_q + PTR_W'(1) : wptr_q;
    assign rptr_d  = rptr_q + PTR_W'(n_pop);

    // Writer list is (lane0, lane1, FIFO head, FIFO head+1) compacted in order.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        s0_en_d   = 1'b0;
        s0_addr_d = 5'd0;
        s0_data_d = 32'd0;
        s1_en_d   = 1'b0;
        s1_addr_d = 5'd0;
        s1_data_d = 32'd0;
        if (e0) begin
            s0_en_d   = 1'b1;
            s0_addr_d = rd0;
            s0_data_d = data0;
            if (e1) begin
                s1_en_d   = 1'b1;
                s1_addr_d = rd1;
                s1_data_d = data1;
            end else if (n_pop != 2'd0) begin
                s1_en_d   = 1'b1;
                s1_addr_d = rd_mem[rptr_q];
                s1_data_d = data_mem[rptr_q];
            end
        end else if (e1) begin
            s0_en_d   = 1'b1;
            s0_addr_d = rd1;
            s0_data_d = data1;
            if (n_pop != 2'd0) begin
                s1_en_d   = 1'b1;
                s1_addr_d = rd_mem[rptr_q];
                s1_data_d = data_mem[rptr_q];
            end
        end else begin
            if (n_pop != 2'd0) begin
                s0_en_d   = 1'b1;
                s0_addr_d = rd_mem[rptr_q];
                s0_data_d = data_mem[rptr_q];
            end
            if (n_pop == 2'd2) begin
                s1_en_d   = 1'b1;
                s1_addr_d = rd_mem[rptr_nx];
                s1_data_d = data_mem[rptr_nx];
            end
        end
    end

    // NOTE: the storage array has no reset; count_q alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wptr_q]   <= lu_rd;
            data_mem[wptr_q] <= lu_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            wp0_en_q   <= 1'b0;
            wp0_addr_q <= 5'd0;
            wp0_data_q <= 32'd0;
            wp1_en_q   <= 1'b0;
            wp1_addr_q <= 5'd0;
            wp1_data_q <= 32'd0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            wp0_en_q   <= s0_en_d;
            wp0_addr_q <= s0_addr_d;
            wp0_data_q <= s0_data_d;
            wp1_en_q   <= s1_en_d;
            wp1_addr_q <= s1_addr_d;
            wp1_data_q <= s1_data_d;
        end
    end

    assign wp0_en     = wp0_en_q;
    assign wp0_addr   = wp0_addr_q;
    assign wp0_data   = wp0_data_q;
    assign wp1_en     = wp1_en_q;
    assign wp1_addr   = wp1_addr_q;
    assign wp1_data   = wp1_data_q;
    assign lu_pending = count_q;

endmodule
